// File: rtl/mips_core_pkg.sv
// Types shared by the rename stage and the issue queue.
package mips_core_pkg;

  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned PTAG_W    = $clog2(PHYS_REGS);

  typedef struct packed {
    logic [3:0]        alu_ctl;
    logic [PTAG_W-1:0] rw_phys;
    logic [PTAG_W-1:0] rs_phys;
    logic [PTAG_W-1:0] rt_phys;
    logic              uses_rs;
    logic              uses_rt;
    logic              uses_rw;
    logic              uses_imm;
    logic [31:0]       immediate;
    logic              is_branch;
    logic [2:0]        branch_type;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_size;
  } iq_entry_t;

endpackage

// File: rtl/iq_oldest_select.sv
// Combinational oldest-candidate picker: grants the valid slot whose age tag is older than
// every other valid slot, using wrap-safe modular comparison.
module iq_oldest_select #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEQ_W = 6
) (
  input  logic [DEPTH-1:0] i_valid,
  input  logic [SEQ_W-1:0] i_seq [DEPTH],
  output logic [DEPTH-1:0] o_grant,
  output logic             o_any
);

  logic             w_win;
  logic [SEQ_W-1:0] w_diff;

  always_comb begin
    o_grant = '0;
    w_win   = 1'b0;
    w_diff  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_win = i_valid[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && i_valid[j]) begin
          // i is older than j iff (seq_i - seq_j) has its MSB set
          w_diff = i_seq[i] - i_seq[j];
          if (!w_diff[SEQ_W-1]) w_win = 1'b0;
        end
      end
      o_grant[i] = w_win;
    end
  end

  assign o_any = |i_valid;

endmodule

// File: rtl/instr_queue.sv
// Out-of-order issue queue: tag-based operand wakeup and oldest-ready-first issue.
module instr_queue
  import mips_core_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PHYS_REGS = mips_core_pkg::PHYS_REGS,
  parameter int unsigned SEQ_W     = $clog2(DEPTH) + 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  iq_entry_t              in_entry,
  input  logic [PHYS_REGS-1:0]   busy_bits,
  input  logic                   wb_valid,
  input  logic [PTAG_W-1:0]      wb_phys,
  input  logic                   flush,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output iq_entry_t              iss_entry,
  output logic [SEQ_W-1:0]       iss_seq,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_rs_rdy;
  logic [DEPTH-1:0] r_rt_rdy;
  iq_entry_t        r_entry [DEPTH];
  logic [SEQ_W-1:0] r_seq   [DEPTH];
  logic [SEQ_W-1:0] r_seq_ctr;
  logic [CNT_W-1:0] r_count;

  logic [IDX_W-1:0] w_free_idx;
  logic [DEPTH-1:0] w_cand;
  logic [DEPTH-1:0] w_grant;
  logic             w_any;
  logic             w_ins;
  logic             w_iss;
  logic             w_rs_rdy_in;
  logic             w_rt_rdy_in;

  assign in_ready = (r_count < CNT_W'(DEPTH));
  assign count    = r_count;
  assign w_ins    = in_valid && in_ready && !flush;
  assign w_cand   = r_valid & r_rs_rdy & r_rt_rdy;

  // Busy-bit snapshot, bypassed by a writeback landing on the same edge
  assign w_rs_rdy_in = !in_entry.uses_rs || !busy_bits[in_entry.rs_phys] ||
                       (wb_valid && wb_phys == in_entry.rs_phys);
  assign w_rt_rdy_in = !in_entry.uses_rt || !busy_bits[in_entry.rt_phys] ||
                       (wb_valid && wb_phys == in_entry.rt_phys);

  always_comb begin
    w_free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
  end

  iq_oldest_select #(
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) u_select (
    .i_valid (w_cand),
    .i_seq   (r_seq),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign iss_valid = w_any && !flush;
  assign w_iss     = iss_valid && iss_ready;

  always_comb begin
    iss_entry = '0;
    iss_seq   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_valid && w_grant[i]) begin
        iss_entry = r_entry[i];
        iss_seq   = r_seq[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= '0;
      r_rs_rdy  <= '0;
      r_rt_rdy  <= '0;
      r_seq_ctr <= '0;
      r_count   <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_valid && r_valid[i]) begin
          if (r_entry[i].rs_phys == wb_phys) r_rs_rdy[i] <= 1'b1;
          if (r_entry[i].rt_phys == wb_phys) r_rt_rdy[i] <= 1'b1;
        end
        if (w_iss && w_grant[i]) r_valid[i] <= 1'b0;
      end
      // Free slot is never the issuing slot, so these writes cannot collide
      if (w_ins) begin
        r_valid[w_free_idx]  <= 1'b1;
        r_entry[w_free_idx]  <= in_entry;
        r_seq[w_free_idx]    <= r_seq_ctr;
        r_rs_rdy[w_free_idx] <= w_rs_rdy_in;
        r_rt_rdy[w_free_idx] <= w_rt_rdy_in;
        r_seq_ctr            <= r_seq_ctr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_ins) - CNT_W'(w_iss);
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: scoreboard of expected issue-order age tags.
module tb_instr_queue;
  import mips_core_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned SEQ_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  iq_entry_t        in_entry;
  logic [63:0]      busy_bits;
  logic             wb_valid;
  logic [PTAG_W-1:0] wb_phys;
  logic             flush;
  logic             iss_valid;
  logic             iss_ready;
  iq_entry_t        iss_entry;
  logic [SEQ_W-1:0] iss_seq;
  logic [4:0]       count;

  int total = 0;
  int bad   = 0;
  logic [SEQ_W-1:0] s;        // model of the queue's age counter
  logic [SEQ_W-1:0] sb [$];   // expected issue order
  logic [SEQ_W-1:0] exp_seq;
  logic [SEQ_W-1:0] tmp;

  always #5 clk = ~clk;

  instr_queue #(.DEPTH(DEPTH), .PHYS_REGS(64), .SEQ_W(SEQ_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .busy_bits (busy_bits),
    .wb_valid  (wb_valid),
    .wb_phys   (wb_phys),
    .flush     (flush),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_entry (iss_entry),
    .iss_seq   (iss_seq),
    .count     (count)
  );

  function automatic iq_entry_t mk(input logic [SEQ_W-1:0] sq, input logic urs,
                                   input logic [PTAG_W-1:0] rs);
    iq_entry_t e;
    e           = '0;
    e.alu_ctl   = sq[3:0];
    e.immediate = {26'd0, sq};
    e.uses_rs   = urs;
    e.rs_phys   = rs;
    e.uses_rw   = 1'b1;
    e.rw_phys   = PTAG_W'(sq);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ins(input logic urs, input logic [PTAG_W-1:0] rs,
                        output logic [SEQ_W-1:0] sq);
    sq       = s;
    in_entry = mk(s, urs, rs);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    s        = s + 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    s   = '0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid: got %0b want 0", iss_valid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (iss_seq !== '0) begin bad++; $display("FAIL reset_iss_seq: got %0d want 0", iss_seq); end
  endtask

  task automatic test_basic();
    do_ins(1'b0, '0, tmp);
    sb.push_back(tmp);
    exp_seq = sb.pop_front();
    total++;
    if (iss_valid !== 1'b1 || iss_seq !== exp_seq || iss_entry.alu_ctl !== exp_seq[3:0]) begin
      bad++;
      $display("FAIL basic_issue: got v=%0b seq=%0d alu=%0d want v=1 seq=%0d alu=%0d",
               iss_valid, iss_seq, iss_entry.alu_ctl, exp_seq, exp_seq[3:0]);
    end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL basic_count: got %0d want 0", count); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_empty: got %0b want 0", iss_valid); end
  endtask

  task automatic test_wakeup();
    logic [SEQ_W-1:0] sa, sbb;
    busy_bits[40] = 1'b1;
    do_ins(1'b1, PTAG_W'(40), sa);
    do_ins(1'b0, '0, sbb);
    sb.push_back(sbb);
    sb.push_back(sa);
    iss_ready = 1'b1;
    exp_seq   = sb.pop_front();
    total++;
    if (iss_valid !== 1'b1 || iss_seq !== exp_seq) begin
      bad++; $display("FAIL wakeup_ready_first: got v=%0b seq=%0d want v=1 seq=%0d", iss_valid, iss_seq, exp_seq);
    end
    tick();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wakeup_blocked: got %0b want 0", iss_valid); end
    wb_valid = 1'b1;
    wb_phys  = PTAG_W'(40);
    tick();
    wb_valid = 1'b0;
    exp_seq  = sb.pop_front();
    total++;
    if (iss_valid !== 1'b1 || iss_seq !== exp_seq) begin
      bad++; $display("FAIL wakeup_after_wb: got v=%0b seq=%0d want v=1 seq=%0d", iss_valid, iss_seq, exp_seq);
    end
    tick();
    iss_ready     = 1'b0;
    busy_bits[40] = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL wakeup_count: got %0d want 0", count); end
  endtask

  task automatic test_bypass();
    busy_bits[12] = 1'b1;
    wb_valid      = 1'b1;
    wb_phys       = PTAG_W'(12);
    do_ins(1'b1, PTAG_W'(12), tmp);
    wb_valid      = 1'b0;
    sb.push_back(tmp);
    exp_seq = sb.pop_front();
    total++;
    if (iss_valid !== 1'b1 || iss_seq !== exp_seq) begin
      bad++; $display("FAIL bypass_issue: got v=%0b seq=%0d want v=1 seq=%0d", iss_valid, iss_seq, exp_seq);
    end
    iss_ready = 1'b1;
    tick();
    iss_ready     = 1'b0;
    busy_bits[12] = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      do_ins(1'b0, '0, tmp);
      sb.push_back(tmp);
    end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count: got %0d want 16", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %0b want 0", in_ready); end
    in_entry = mk(s, 1'b0, '0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL full_17th_dropped: got %0d want 16", count); end
    iss_ready = 1'b1;
    exp_seq   = sb.pop_front();
    total++;
    if (iss_valid !== 1'b1 || iss_seq !== exp_seq) begin
      bad++; $display("FAIL full_oldest: got v=%0b seq=%0d want v=1 seq=%0d", iss_valid, iss_seq, exp_seq);
    end
    tick();
    iss_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_in_ready_after: got %0b want 1", in_ready); end
    total++; if (count !== 5'd15) begin bad++; $display("FAIL full_count_after: got %0d want 15", count); end
    iss_ready = 1'b1;
    while (sb.size() > 0) begin
      exp_seq = sb.pop_front();
      total++;
      if (iss_valid !== 1'b1 || iss_seq !== exp_seq) begin
        bad++; $display("FAIL full_drain: got v=%0b seq=%0d want v=1 seq=%0d", iss_valid, iss_seq, exp_seq);
      end
      tick();
    end
    iss_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL full_drained: got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    int n;
    logic [SEQ_W-1:0] sq_q;
    n = int'(SEQ_W'(60 - s));
    // Stream ready entries straight through to advance the age counter
    in_valid  = 1'b1;
    iss_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_entry = mk(s, 1'b0, '0);
      tick();
      s = s + 1'b1;
    end
    in_valid = 1'b0;
    tick();
    iss_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL wrap_stream_drained: got %0d want 0", count); end
    busy_bits[50] = 1'b1;
    do_ins(1'b0, '0, tmp);               // 60, slot 0
    do_ins(1'b1, PTAG_W'(50), sq_q);     // 61, waits on tag 50
    do_ins(1'b0, '0, tmp); sb.push_back(tmp);
    do_ins(1'b0, '0, tmp); sb.push_back(tmp);
    iss_ready = 1'b1;
    total++;
    if (iss_valid !== 1'b1 || iss_seq !== 6'd60) begin
      bad++; $display("FAIL wrap_first: got v=%0b seq=%0d want v=1 seq=60", iss_valid, iss_seq);
    end
    tick();
    iss_ready = 1'b0;
    do_ins(1'b0, '0, tmp);               // seq 0 lands in the freed slot 0
    sb.push_back(tmp);
    iss_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_seq = sb.pop_front();
      total++;
      if (iss_valid !== 1'b1 || iss_seq !== exp_seq) begin
        bad++; $display("FAIL wrap_order: got v=%0b seq=%0d want v=1 seq=%0d", iss_valid, iss_seq, exp_seq);
      end
      tick();
    end
    iss_ready = 1'b0;
    wb_valid  = 1'b1;
    wb_phys   = PTAG_W'(50);
    tick();
    wb_valid = 1'b0;
    total++;
    if (iss_valid !== 1'b1 || iss_seq !== sq_q) begin
      bad++; $display("FAIL wrap_late_wake: got v=%0b seq=%0d want v=1 seq=%0d", iss_valid, iss_seq, sq_q);
    end
    iss_ready = 1'b1;
    tick();
    iss_ready     = 1'b0;
    busy_bits[50] = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) do_ins(1'b0, '0, tmp);
    total++; if (count !== 5'd5) begin bad++; $display("FAIL flush_pre_count: got %0d want 5", count); end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_entry  = mk(s, 1'b0, '0);
    iss_ready = 1'b1;
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_masks_issue: got %0b want 0", iss_valid); end
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    iss_ready = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", count); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_iss_valid: got %0b want 0", iss_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    do_ins(1'b0, '0, tmp);               // age counter survives flush
    sb.push_back(tmp);
    exp_seq = sb.pop_front();
    total++;
    if (iss_valid !== 1'b1 || iss_seq !== exp_seq) begin
      bad++; $display("FAIL flush_seq_kept: got v=%0b seq=%0d want v=1 seq=%0d", iss_valid, iss_seq, exp_seq);
    end
    // Reset mid-operation clears the queue and the age counter
    do_ins(1'b0, '0, tmp);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s   = '0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    do_ins(1'b0, '0, tmp);
    sb.push_back(tmp);
    exp_seq = sb.pop_front();
    total++;
    if (iss_valid !== 1'b1 || iss_seq !== exp_seq) begin
      bad++; $display("FAIL rst_mid_seq: got v=%0b seq=%0d want v=1 seq=%0d", iss_valid, iss_seq, exp_seq);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_entry  = '0;
    busy_bits = '0;
    wb_valid  = 1'b0;
    wb_phys   = '0;
    flush     = 1'b0;
    iss_ready = 1'b0;
    s         = '0;
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_wrap();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
